// File: rtl/rally_controller.sv
// Pong match sequencer: serve/rally/point/over flow, scores, ball step rate and paddle width.
// Define LFSR_SERVE_EN to pick each serve direction from a 16-bit LFSR instead of alternating.
module rally_controller #(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 25000000,
  parameter int BASE_DIV    = 262144,
  parameter int MIN_DIV     = 65536,
  parameter int DIV_STEP    = 16384,
  parameter int PAD_MAX     = 40,
  parameter int PAD_MIN     = 16,
  parameter int PAD_STEP    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hit_0,
  input  logic       hit_1,
  input  logic       score_evt,
  input  logic [1:0] who_scored,
  output logic [3:0] gamestate,
  output logic [3:0] num_0,
  output logic [3:0] num_1,
  output logic [1:0] winner,
  output logic       ball_tick,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [5:0] paddlewidth
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_SERVE = 4'd1,
    S_RALLY = 4'd2,
    S_POINT = 4'd3,
    S_OVER  = 4'd4
  } state_t;

  localparam logic [24:0] L_TIMER_LOAD = 25'(SERVE_DELAY - 1);
  localparam logic [19:0] L_BASE_DIV   = 20'(BASE_DIV);
  localparam logic [19:0] L_MIN_DIV    = 20'(MIN_DIV);
  localparam logic [19:0] L_DIV_STEP   = 20'(DIV_STEP);
  localparam logic [20:0] L_DIV_FLOOR  = 21'(MIN_DIV + DIV_STEP);
  localparam logic [5:0]  L_PAD_MAX    = 6'(PAD_MAX);
  localparam logic [5:0]  L_PAD_MIN    = 6'(PAD_MIN);
  localparam logic [5:0]  L_PAD_STEP   = 6'(PAD_STEP);
  localparam logic [6:0]  L_PAD_FLOOR  = 7'(PAD_MIN + PAD_STEP);
  localparam logic [3:0]  L_WIN        = 4'(WIN_SCORE);

  state_t      r_state;
  logic [3:0]  r_num0;
  logic [3:0]  r_num1;
  logic [1:0]  r_winner;
  logic        r_tick;
  logic        r_ballReset;
  logic        r_serveDir;
  logic [5:0]  r_padW;
  logic [19:0] r_div;
  logic [19:0] r_cnt;
  logic [24:0] r_timer;

  logic       w_hit;
  logic       w_scoreP0;
  logic       w_scoreP1;
  logic       w_score;
  logic       w_enterServe;
  logic       w_serveDir;
  logic [3:0] w_newScore;

  assign w_hit        = hit_0 | hit_1;
  assign w_scoreP0    = score_evt && (who_scored == 2'b01);
  assign w_scoreP1    = score_evt && (who_scored == 2'b10);
  assign w_score      = w_scoreP0 | w_scoreP1;
  assign w_newScore   = w_scoreP0 ? (r_num0 + 4'd1) : (r_num1 + 4'd1);
  assign w_enterServe = (((r_state == S_IDLE) || (r_state == S_OVER)) && start) ||
                        ((r_state == S_POINT) && (r_timer == 25'd0));

`ifdef LFSR_SERVE_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_serveDir = r_lfsr[0];
`else
  assign w_serveDir = ~r_serveDir;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_num0      <= '0;
      r_num1      <= '0;
      r_winner    <= '0;
      r_tick      <= 1'b0;
      r_ballReset <= 1'b1;
      r_serveDir  <= 1'b0;
      r_padW      <= L_PAD_MAX;
      r_div       <= L_BASE_DIV;
      r_timer     <= '0;
      r_cnt       <= '0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (start) begin
            r_num0   <= '0;
            r_num1   <= '0;
            r_winner <= '0;
            r_padW   <= L_PAD_MAX;
          end
        end
        S_SERVE: begin
          if (r_timer == 25'd0) begin
            r_state     <= S_RALLY;
            r_ballReset <= 1'b0;
            r_cnt       <= '0;
          end else begin
            r_timer <= r_timer - 25'd1;
          end
        end
        S_RALLY: begin
          // A valid score ends the rally and swallows any hit or tick in the same cycle.
          if (w_score) begin
            r_ballReset <= 1'b1;
            if (w_scoreP0) r_num0 <= w_newScore;
            else           r_num1 <= w_newScore;
            if (w_newScore == L_WIN) begin
              r_state  <= S_OVER;
              r_winner <= w_scoreP0 ? 2'b01 : 2'b10;
            end else begin
              r_state <= S_POINT;
              r_timer <= L_TIMER_LOAD;
            end
          end else begin
            if (r_cnt >= r_div - 20'd1) begin
              r_tick <= 1'b1;
              r_cnt  <= '0;
            end else begin
              r_cnt <= r_cnt + 20'd1;
            end
            if (w_hit) begin
              if ({1'b0, r_div} >= L_DIV_FLOOR) r_div <= r_div - L_DIV_STEP;
              else                              r_div <= L_MIN_DIV;
              if ({1'b0, r_padW} >= L_PAD_FLOOR) r_padW <= r_padW - L_PAD_STEP;
              else                               r_padW <= L_PAD_MIN;
            end
          end
        end
        S_POINT: begin
          if (r_timer != 25'd0) r_timer <= r_timer - 25'd1;
        end
        default: r_state <= S_IDLE;
      endcase
      // Every way into SERVE restarts the ball at its base speed.
      if (w_enterServe) begin
        r_state     <= S_SERVE;
        r_timer     <= L_TIMER_LOAD;
        r_div       <= L_BASE_DIV;
        r_serveDir  <= w_serveDir;
        r_ballReset <= 1'b1;
      end
    end
  end

  assign gamestate   = r_state;
  assign num_0       = r_num0;
  assign num_1       = r_num1;
  assign winner      = r_winner;
  assign ball_tick   = r_tick;
  assign ball_reset  = r_ballReset;
  assign serve_dir   = r_serveDir;
  assign paddlewidth = r_padW;

endmodule

// File: tb/tb_rally_controller.sv
// Directed self-checking bench for rally_controller with small timing parameters.
module tb_rally_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       hit_0;
  logic       hit_1;
  logic       score_evt;
  logic [1:0] who_scored;
  logic [3:0] gamestate;
  logic [3:0] num_0;
  logic [3:0] num_1;
  logic [1:0] winner;
  logic       ball_tick;
  logic       ball_reset;
  logic       serve_dir;
  logic [5:0] paddlewidth;

  logic [22:0] snap;
  logic [22:0] expSnap;
  logic        expDir;
  int          checks = 0;
  int          failures = 0;

  rally_controller #(
    .WIN_SCORE(2), .SERVE_DELAY(4), .BASE_DIV(8), .MIN_DIV(4), .DIV_STEP(2),
    .PAD_MAX(40), .PAD_MIN(36), .PAD_STEP(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hit_0(hit_0), .hit_1(hit_1),
    .score_evt(score_evt), .who_scored(who_scored), .gamestate(gamestate),
    .num_0(num_0), .num_1(num_1), .winner(winner), .ball_tick(ball_tick),
    .ball_reset(ball_reset), .serve_dir(serve_dir), .paddlewidth(paddlewidth)
  );

  always #5 clk = ~clk;

  assign snap = {gamestate, num_0, num_1, winner, ball_tick, ball_reset, serve_dir, paddlewidth};

`ifdef LFSR_SERVE_EN
  logic [15:0] refLfsr;
  logic [15:0] preLfsr;
  always @(posedge clk) begin
    if (reset) refLfsr <= 16'hACE1;
    else       refLfsr <= {refLfsr[14:0], refLfsr[15] ^ refLfsr[13] ^ refLfsr[12] ^ refLfsr[10]};
  end
`endif

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic stepClk();
`ifdef LFSR_SERVE_EN
    preLfsr = refLfsr;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic serveEntered();
`ifdef LFSR_SERVE_EN
    expDir = preLfsr[0];
`else
    expDir = ~expDir;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; hit_0 = 1'b0; hit_1 = 1'b0;
    score_evt = 1'b0; who_scored = 2'b00;
    stepClk(); stepClk();
    expSnap = {4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0, 6'd40};
    checks++;
    if (snap !== expSnap) begin
      failures++; $display("FAIL reset_values got=%h exp=%h", snap, expSnap);
    end
    reset = 1'b0; expDir = 1'b0;
    stepClk();
    checks++;
    if (snap !== expSnap) begin
      failures++; $display("FAIL idle_hold got=%h exp=%h", snap, expSnap);
    end
  endtask

  task automatic test_serve();
    start = 1'b1; stepClk(); start = 1'b0; serveEntered();
    for (int i = 0; i < 4; i++) begin
      expSnap = {4'd1, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1, expDir, 6'd40};
      checks++;
      if (snap !== expSnap) begin
        failures++; $display("FAIL serve_cycle%0d got=%h exp=%h", i, snap, expSnap);
      end
      stepClk();
    end
    expSnap = {4'd2, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, expDir, 6'd40};
    checks++;
    if (snap !== expSnap) begin
      failures++; $display("FAIL rally_entry got=%h exp=%h", snap, expSnap);
    end
    for (int n = 1; n <= 24; n++) begin
      stepClk();
      checks++;
      if ({gamestate, ball_tick, ball_reset} !== {4'd2, (n % 8) == 0, 1'b0}) begin
        failures++;
        $display("FAIL tick_base cyc=%0d got_state=%0d got_tick=%b exp_tick=%b",
                 n, gamestate, ball_tick, (n % 8) == 0);
      end
    end
  endtask

  task automatic test_hits();
    bit found;
    hit_0 = 1'b1; hit_1 = 1'b1; stepClk(); hit_0 = 1'b0; hit_1 = 1'b0;
    checks++;
    if (paddlewidth !== 6'd38) begin
      failures++; $display("FAIL dual_hit_width got=%0d exp=38", paddlewidth);
    end
    hit_0 = 1'b1; stepClk(); hit_0 = 1'b0;
    checks++;
    if (paddlewidth !== 6'd36) begin
      failures++; $display("FAIL hit2_width got=%0d exp=36", paddlewidth);
    end
    hit_0 = 1'b1; stepClk(); hit_0 = 1'b0;
    checks++;
    if (paddlewidth !== 6'd36) begin
      failures++; $display("FAIL hit3_width_floor got=%0d exp=36", paddlewidth);
    end
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      stepClk();
      found = ball_tick;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL tick_after_hits got=none exp=tick within 20 cycles");
    end
    for (int k = 1; k <= 8; k++) begin
      stepClk();
      checks++;
      if (ball_tick !== ((k % 4) == 0)) begin
        failures++; $display("FAIL tick_fast cyc=%0d got=%b exp=%b", k, ball_tick, (k % 4) == 0);
      end
    end
  endtask

  task automatic test_point();
    score_evt = 1'b1; who_scored = 2'b01; stepClk(); score_evt = 1'b0; who_scored = 2'b00;
    expSnap = {4'd3, 4'd1, 4'd0, 2'b00, 1'b0, 1'b1, expDir, 6'd36};
    checks++;
    if (snap !== expSnap) begin
      failures++; $display("FAIL point_entry got=%h exp=%h", snap, expSnap);
    end
    for (int i = 1; i < 4; i++) begin
      stepClk();
      checks++;
      if (snap !== expSnap) begin
        failures++; $display("FAIL point_cycle%0d got=%h exp=%h", i, snap, expSnap);
      end
    end
    stepClk(); serveEntered();
    expSnap = {4'd1, 4'd1, 4'd0, 2'b00, 1'b0, 1'b1, expDir, 6'd36};
    checks++;
    if (snap !== expSnap) begin
      failures++; $display("FAIL reserve_entry got=%h exp=%h", snap, expSnap);
    end
    for (int i = 0; i < 4; i++) stepClk();
    checks++;
    if (gamestate !== 4'd2) begin
      failures++; $display("FAIL reserve_to_rally got=%0d exp=2", gamestate);
    end
    for (int n = 1; n <= 8; n++) begin
      stepClk();
      checks++;
      if (ball_tick !== (n == 8)) begin
        failures++; $display("FAIL div_restored cyc=%0d got=%b exp=%b", n, ball_tick, n == 8);
      end
    end
  endtask

  task automatic test_over();
    score_evt = 1'b1; who_scored = 2'b01; stepClk(); score_evt = 1'b0; who_scored = 2'b00;
    expSnap = {4'd4, 4'd2, 4'd0, 2'b01, 1'b0, 1'b1, expDir, 6'd36};
    checks++;
    if (snap !== expSnap) begin
      failures++; $display("FAIL over_entry got=%h exp=%h", snap, expSnap);
    end
    hit_0 = 1'b1; score_evt = 1'b1; who_scored = 2'b10; stepClk();
    hit_0 = 1'b0; score_evt = 1'b0; who_scored = 2'b00;
    stepClk(); stepClk();
    checks++;
    if (snap !== expSnap) begin
      failures++; $display("FAIL over_hold got=%h exp=%h", snap, expSnap);
    end
    start = 1'b1; stepClk(); start = 1'b0; serveEntered();
    expSnap = {4'd1, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1, expDir, 6'd40};
    checks++;
    if (snap !== expSnap) begin
      failures++; $display("FAIL restart got=%h exp=%h", snap, expSnap);
    end
  endtask

  task automatic test_score_priority();
    for (int i = 0; i < 4; i++) stepClk();
    checks++;
    if (gamestate !== 4'd2) begin
      failures++; $display("FAIL restart_rally got=%0d exp=2", gamestate);
    end
    score_evt = 1'b1; who_scored = 2'b10; hit_1 = 1'b1; stepClk();
    score_evt = 1'b0; who_scored = 2'b00; hit_1 = 1'b0;
    expSnap = {4'd3, 4'd0, 4'd1, 2'b00, 1'b0, 1'b1, expDir, 6'd40};
    checks++;
    if (snap !== expSnap) begin
      failures++; $display("FAIL score_beats_hit got=%h exp=%h", snap, expSnap);
    end
    for (int i = 0; i < 4; i++) stepClk();
    serveEntered();
    checks++;
    if ({gamestate, serve_dir} !== {4'd1, expDir}) begin
      failures++; $display("FAIL serve_dir_p1 got=%0d/%b exp=1/%b", gamestate, serve_dir, expDir);
    end
    for (int i = 0; i < 4; i++) stepClk();
    score_evt = 1'b1; who_scored = 2'b11; stepClk();
    who_scored = 2'b00; stepClk(); score_evt = 1'b0;
    expSnap = {4'd2, 4'd0, 4'd1, 2'b00, 1'b0, 1'b0, expDir, 6'd40};
    checks++;
    if ({snap[22:4], snap[2:0]} !== {expSnap[22:4], expSnap[2:0]}) begin
      failures++; $display("FAIL bad_who_ignored got=%h exp=%h", snap, expSnap);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; stepClk(); reset = 1'b0; expDir = 1'b0;
    expSnap = {4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0, 6'd40};
    checks++;
    if (snap !== expSnap) begin
      failures++; $display("FAIL reset_mid got=%h exp=%h", snap, expSnap);
    end
    start = 1'b1; stepClk(); start = 1'b0; serveEntered();
    checks++;
    if ({gamestate, serve_dir} !== {4'd1, expDir}) begin
      failures++; $display("FAIL serve_after_reset got=%0d/%b exp=1/%b", gamestate, serve_dir, expDir);
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_hits();
    test_point();
    test_over();
    test_score_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
